// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the execute stage and the multiply/divide unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle signed/unsigned multiply/divide unit with HI/LO registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          resetn,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd;    // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [2*WIDTH-1:0] acc;     // product accumulator; low half doubles as dividend/quotient
  logic [WIDTH:0]     rem;     // partial remainder for restoring division
  logic               is_div;
  logic               neg_q;   // negate product / quotient at FIX
  logic               neg_r;   // negate remainder at FIX
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               borrow;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Operand magnitudes at accept, one iteration step, and sign correction for FIX
  always_comb begin
    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.a[WIDTH-1];
    b_neg     = signed_op & bus.b[WIDTH-1];
    mag_a     = a_neg ? -bus.a : bus.a;
    mag_b     = b_neg ? -bus.b : bus.b;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    borrow    = div_diff[WIDTH+1];
    prod      = neg_q ? -acc : acc;
    quo       = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd       = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  // Control FSM plus datapath registers: accept, iterate WIDTH times, then sign-fix and write HI/LO
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      opnd   <= '0;
      acc    <= '0;
      rem    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (!bus.op[2]) begin
              state  <= RUN;
              busy_q <= 1'b1;
              cnt    <= '0;
              rem    <= '0;
              is_div <= bus.op[1];
              neg_r  <= a_neg;
              if (bus.op[1]) begin
                // a zero divisor must leave the all-ones quotient un-negated
                neg_q <= (a_neg ^ b_neg) & (bus.b != '0);
                opnd  <= mag_b;
                acc   <= {{WIDTH{1'b0}}, mag_a};
              end else begin
                neg_q <= a_neg ^ b_neg;
                opnd  <= mag_a;
                acc   <= {{WIDTH{1'b0}}, mag_b};
              end
            end else if (!bus.op[1]) begin
              if (!bus.op[0]) hi_q <= bus.a;
              else            lo_q <= bus.a;
            end
          end
        end
        RUN: begin
          if (is_div) begin
            rem             <= borrow ? div_shift : div_diff[WIDTH:0];
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], ~borrow};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi_q <= rmd;
            lo_q <= quo;
          end else begin
            hi_q <= prod[2*WIDTH-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  muldiv_unit_if #(.WIDTH(WIDTH)) mif ();
  muldiv_unit #(.WIDTH(WIDTH)) dut (.clock(clock), .resetn(resetn), .bus(mif));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b1;

  // reference model state
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          m_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void reference(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, p, q, r;
    longint unsigned up;
    logic [63:0] v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v  = '0;
    case (op)
      3'd0: begin p = sa * sb; v = p; end
      3'd1: begin up = {32'b0, a} * {32'b0, b}; v = up; end
      default: begin
        if (b == 32'd0) v = {a, 32'hFFFF_FFFF};
        else if (op == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          v = {r[31:0], q[31:0]};
        end else v = {a % b, a / b};
      end
    endcase
    h = v[63:32];
    l = v[31:0];
  endfunction

  task automatic model_step(input bit st, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit rn);
    if (!rn) begin
      m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
    end else if (st) begin
      if (op < 3'd4) begin
        reference(op, a, b, p_hi, p_lo);
        m_left = WIDTH + 1;
      end else if (op == 3'd4) m_hi = a;
      else if (op == 3'd5) m_lo = a;
    end
  endtask

  // one clock: drive inputs, advance the model at the edge, return at the following falling edge
  task automatic cycle(input bit st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit rn);
    mif.start = st; mif.op = op; mif.a = a; mif.b = b; resetn = rn;
    @(posedge clock);
    model_step(st, op, a, b, rn);
    @(negedge clock);
  endtask

  task automatic idle();
    cycle(1'b0, 3'd0, $urandom, $urandom, 1'b1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int bcnt, output int dcnt);
    cycle(1'b1, op, a, b, 1'b1);
    bcnt = int'(mif.busy);
    dcnt = int'(mif.done);
    for (int i = 1; i <= WIDTH + 1; i++) begin
      idle();
      bcnt += int'(mif.busy);
      dcnt += int'(mif.done);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // per-cycle comparison of every output against the model
  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", {31'b0, mif.busy}, {31'b0, m_left > 0});
      check("done", {31'b0, mif.done}, {31'b0, m_done});
      check("hi", mif.hi, m_hi);
      check("lo", mif.lo, m_lo);
    end
  end

  initial begin
    int bc, dc, n;
    logic [2:0] op;
    logic [31:0] a, b;
    bit rst;
    mif.start = 1'b0; mif.op = '0; mif.a = '0; mif.b = '0; resetn = 1'b0;

    cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    check("rst_busy", {31'b0, mif.busy}, 32'd0);
    check("rst_done", {31'b0, mif.done}, 32'd0);
    check("rst_hi", mif.hi, 32'd0);
    check("rst_lo", mif.lo, 32'd0);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, bc, dc);
    check("mult_hi", mif.hi, 32'hFFFF_FFFF);
    check("mult_lo", mif.lo, 32'hFFFF_FFF1);
    check("mult_busy_cycles", bc, 32'd33);
    check("mult_done_pulses", dc, 32'd1);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
    check("multu_hi", mif.hi, 32'hFFFF_FFFE);
    check("multu_lo", mif.lo, 32'h0000_0001);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, bc, dc);
    check("div_b2b_lo", mif.lo, 32'hFFFF_FFFD);
    check("div_b2b_hi", mif.hi, 32'hFFFF_FFFF);
    check("div_b2b_busy", bc, 32'd33);

    run_op(3'd3, 32'd7, 32'd0, bc, dc);
    check("divu0_lo", mif.lo, 32'hFFFF_FFFF);
    check("divu0_hi", mif.hi, 32'h7);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
    check("divovf_lo", mif.lo, 32'h8000_0000);
    check("divovf_hi", mif.hi, 32'h0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'h10, bc, dc);
    check("divu16_lo", mif.lo, 32'h0FFF_FFFF);
    check("divu16_hi", mif.hi, 32'hF);

    cycle(1'b1, 3'd4, 32'h1234_5678, 32'h0, 1'b1);
    check("mthi_hi", mif.hi, 32'h1234_5678);
    check("mthi_busy", {31'b0, mif.busy}, 32'd0);
    check("mthi_done", {31'b0, mif.done}, 32'd0);

    cycle(1'b1, 3'd0, 32'd3, 32'd3, 1'b1);
    for (int i = 1; i <= WIDTH + 1; i++) begin
      if (i == 2)       cycle(1'b1, 3'd5, 32'hDEAD_BEEF, 32'h0, 1'b1);
      else if (i == 5)  cycle(1'b1, 3'd0, 32'd100, 32'd100, 1'b1);
      else if (i == 32) cycle(1'b1, 3'd2, 32'd50, 32'd7, 1'b1);
      else idle();
      if (i == 20) begin
        check("blocked_hi", mif.hi, 32'h1234_5678);
        check("blocked_lo", mif.lo, 32'h0FFF_FFFF);
      end
    end
    check("blocked_res_hi", mif.hi, 32'h0);
    check("blocked_res_lo", mif.lo, 32'h9);
    idle();
    check("blocked_no_op", {31'b0, mif.busy}, 32'd0);

    cycle(1'b1, 3'd0, 32'h1234, 32'h5678, 1'b1);
    repeat (10) idle();
    cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    check("abort_busy", {31'b0, mif.busy}, 32'd0);
    check("abort_done", {31'b0, mif.done}, 32'd0);
    check("abort_hi", mif.hi, 32'h0);
    check("abort_lo", mif.lo, 32'h0);
    run_op(3'd0, 32'd6, 32'd7, bc, dc);
    check("post_abort_hi", mif.hi, 32'h0);
    check("post_abort_lo", mif.lo, 32'h2A);

    for (int k = 0; k < 250; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      cycle(1'b1, op, a, b, 1'b1);
      n = 0;
      while (m_left > 0 && n < 40) begin
        n++;
        rst = ($urandom_range(0, 99) == 0);
        cycle($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), pick(), pick(), !rst);
      end
      repeat ($urandom_range(0, 2)) idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
